// File: rtl/mod_updown_counter_if.sv
// Counter control/status bundle: the counter is the slave, its user the master.
interface mod_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr;
   logic             ovf_clr;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             ovf;

   modport master (
      output en, up_dn, load, load_val, clr, ovf_clr,
      input  count, tc, wrap, ovf
   );

   modport slave (
      input  en, up_dn, load, load_val, clr, ovf_clr,
      output count, tc, wrap, ovf
   );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, parallel load, synchronous clear,
// wrap-or-saturate boundary behaviour, a one-cycle wrap pulse and a sticky
// overflow flag. tc is combinational so instances can be cascaded.
module mod_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   mod_updown_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [31:0]      MOD_EXT = 32'(MODULUS);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             tc;
   logic             boundary_evt;
   logic [WIDTH-1:0] load_clamped;

   // Terminal count depends only on the current count and direction, not on en.
   always_comb begin
      tc = bus.up_dn ? (count_q == MAX_CNT) : (count_q == '0);
   end

   // Boundary event: an enabled step that would leave the 0..MODULUS-1 range.
   always_comb begin
      boundary_evt = bus.en && !bus.clr && !bus.load && tc;
      load_clamped = (32'(bus.load_val) < MOD_EXT) ? bus.load_val : MAX_CNT;
   end

   // Next-state logic: clr > load > en > hold for count; wrap/ovf follow events.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      count_d = count_q;
      wrap_d  = boundary_evt;
      ovf_d   = ovf_q;

      if (bus.clr) begin
         count_d = '0;
      end else if (bus.load) begin
         count_d = load_clamped;
      end else if (bus.en) begin
         if (tc) begin
            if (!SATURATE) begin
               count_d = bus.up_dn ? '0 : MAX_CNT;
            end
         end else begin
            count_d = bus.up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
         end
      end

      // Set is applied after clear so a coincident event keeps the flag high.
      if (bus.ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (boundary_evt) begin
         ovf_d = 1'b1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc;
   assign bus.wrap  = wrap_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: wrap-mode and saturate-mode counters driven from vector
// tables, hand sequences for asynchronous reset, and a two-stage cascade.
module tb_mod_updown_counter;

   typedef struct {
      logic       en;
      logic       up_dn;
      logic       load;
      logic [3:0] load_val;
      logic       clr;
      logic       ovf_clr;
      int         exp_count;
      logic       exp_tc;
      logic       exp_wrap;
      logic       exp_ovf;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mod_updown_counter_if #(.WIDTH(4)) ia  ();
   mod_updown_counter_if #(.WIDTH(4)) ib  ();
   mod_updown_counter_if #(.WIDTH(4)) ilo ();
   mod_updown_counter_if #(.WIDTH(4)) ihi ();

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
      .clk(clk), .reset(reset), .bus(ia));
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (
      .clk(clk), .reset(reset), .bus(ib));
   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_lo (
      .clk(clk), .reset(reset), .bus(ilo));
   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_hi (
      .clk(clk), .reset(reset), .bus(ihi));

   // High stage advances only when the low stage is enabled and at terminal count.
   assign ihi.en = ilo.en & ilo.tc;

   function automatic vec_t mk(logic en, logic up_dn, logic load, logic [3:0] load_val,
                               logic clr, logic ovf_clr, int c, logic t, logic w, logic o);
      vec_t v;
      v.en = en; v.up_dn = up_dn; v.load = load; v.load_val = load_val;
      v.clr = clr; v.ovf_clr = ovf_clr;
      v.exp_count = c; v.exp_tc = t; v.exp_wrap = w; v.exp_ovf = o;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t va[$];
   vec_t vb[$];

   initial begin
      // Wrap-mode counter, MODULUS=10.
      for (int k = 1; k <= 8; k++) va.push_back(mk(1, 1, 0, 0, 0, 0, k, 0, 0, 0));
      va.push_back(mk(1, 1, 0, 0,  0, 0, 9, 1, 0, 0));
      va.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 1, 1));
      va.push_back(mk(1, 1, 0, 0,  0, 0, 1, 0, 0, 1));
      va.push_back(mk(0, 0, 1, 1,  0, 0, 1, 0, 0, 1));
      va.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1, 0, 1));
      va.push_back(mk(1, 0, 0, 0,  0, 0, 9, 0, 1, 1));
      va.push_back(mk(1, 0, 0, 0,  0, 0, 8, 0, 0, 1));
      va.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 0, 1));
      va.push_back(mk(1, 0, 0, 0,  0, 1, 9, 0, 1, 1));
      va.push_back(mk(0, 0, 0, 0,  0, 1, 9, 0, 0, 0));
      va.push_back(mk(0, 0, 0, 0,  0, 0, 9, 0, 0, 0));
      va.push_back(mk(0, 1, 1, 12, 0, 0, 9, 1, 0, 0));
      va.push_back(mk(0, 1, 1, 5,  1, 0, 0, 0, 0, 0));
      va.push_back(mk(1, 1, 1, 5,  0, 0, 5, 0, 0, 0));
      va.push_back(mk(0, 1, 1, 10, 0, 0, 9, 1, 0, 0));
      va.push_back(mk(1, 1, 1, 9,  0, 0, 9, 1, 0, 0));
      va.push_back(mk(1, 1, 0, 0,  1, 0, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 1, 15, 0, 0, 9, 1, 0, 0));
      va.push_back(mk(0, 1, 1, 5,  0, 0, 5, 0, 0, 0));
      va.push_back(mk(1, 1, 0, 0,  0, 0, 6, 0, 0, 0));
      va.push_back(mk(1, 0, 0, 0,  0, 0, 5, 0, 0, 0));
      va.push_back(mk(1, 1, 0, 0,  0, 0, 6, 0, 0, 0));
      va.push_back(mk(0, 0, 1, 0,  0, 0, 0, 1, 0, 0));
      va.push_back(mk(1, 0, 0, 0,  0, 0, 9, 0, 1, 1));
      va.push_back(mk(0, 1, 1, 6,  0, 0, 6, 0, 0, 1));

      // Saturate-mode counter, MODULUS=10.
      vb.push_back(mk(0, 1, 1, 7, 0, 0, 7, 0, 0, 0));
      vb.push_back(mk(1, 1, 0, 0, 0, 0, 8, 0, 0, 0));
      vb.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 0, 0));
      vb.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 1, 1));
      vb.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 1, 1));
      vb.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 1, 1));
      vb.push_back(mk(1, 0, 0, 0, 0, 0, 8, 0, 0, 1));
      vb.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1));
      vb.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      vb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
      vb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));

      {ia.en, ia.up_dn, ia.load, ia.load_val, ia.clr, ia.ovf_clr} = '0;
      {ib.en, ib.up_dn, ib.load, ib.load_val, ib.clr, ib.ovf_clr} = '0;
      {ilo.en, ilo.up_dn, ilo.load, ilo.load_val, ilo.clr, ilo.ovf_clr} = '0;
      {ihi.up_dn, ihi.load, ihi.load_val, ihi.clr, ihi.ovf_clr} = '0;

      // Reset state, and tc following up_dn combinationally.
      #2;
      check("reset count", 32'(ia.count), 0);
      check("reset wrap",  32'(ia.wrap),  0);
      check("reset ovf",   32'(ia.ovf),   0);
      check("reset tc dn", 32'(ia.tc),    1);
      ia.up_dn = 1'b1;
      #1;
      check("reset tc up", 32'(ia.tc),    0);
      ia.en = 1'b1;
      step();
      check("reset held", 32'(ia.count), 0);

      @(negedge clk);
      reset = 1'b1;

      foreach (va[i]) begin
         ia.en = va[i].en; ia.up_dn = va[i].up_dn; ia.load = va[i].load;
         ia.load_val = va[i].load_val; ia.clr = va[i].clr; ia.ovf_clr = va[i].ovf_clr;
         step();
         check($sformatf("A[%0d] count", i), 32'(ia.count), 32'(va[i].exp_count));
         check($sformatf("A[%0d] tc", i),    32'(ia.tc),    32'(va[i].exp_tc));
         check($sformatf("A[%0d] wrap", i),  32'(ia.wrap),  32'(va[i].exp_wrap));
         check($sformatf("A[%0d] ovf", i),   32'(ia.ovf),   32'(va[i].exp_ovf));
      end

      // Asynchronous reset between edges with count=6 and ovf=1.
      {ia.en, ia.load, ia.clr, ia.ovf_clr} = '0;
      ia.up_dn = 1'b1;
      #3;
      reset = 1'b0;
      #1;
      check("async count", 32'(ia.count), 0);
      check("async wrap",  32'(ia.wrap),  0);
      check("async ovf",   32'(ia.ovf),   0);
      ia.en = 1'b1;
      step();
      step();
      check("async hold count", 32'(ia.count), 0);
      check("async hold ovf",   32'(ia.ovf),   0);
      @(negedge clk);
      reset = 1'b1;
      step();
      check("release first count", 32'(ia.count), 1);
      ia.en = 1'b0;

      foreach (vb[i]) begin
         ib.en = vb[i].en; ib.up_dn = vb[i].up_dn; ib.load = vb[i].load;
         ib.load_val = vb[i].load_val; ib.clr = vb[i].clr; ib.ovf_clr = vb[i].ovf_clr;
         step();
         check($sformatf("B[%0d] count", i), 32'(ib.count), 32'(vb[i].exp_count));
         check($sformatf("B[%0d] tc", i),    32'(ib.tc),    32'(vb[i].exp_tc));
         check($sformatf("B[%0d] wrap", i),  32'(ib.wrap),  32'(vb[i].exp_wrap));
         check($sformatf("B[%0d] ovf", i),   32'(ib.ovf),   32'(vb[i].exp_ovf));
      end

      // Cascade: 300 enabled cycles up, combined value tracks n mod 256.
      ilo.up_dn = 1'b1;
      ihi.up_dn = 1'b1;
      ilo.en    = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         step();
         check($sformatf("cascade n=%0d", n), 32'({ihi.count, ilo.count}), 32'(n % 256));
      end
      ilo.en = 1'b0;
      step();
      check("cascade final", 32'({ihi.count, ilo.count}), 44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous up/down counter with a programmable modulus, parallel load, synchronous clear and a choice of wrap or saturate at the boundaries. It is the successor to the fixed 4-bit synchronous counter. It serves as the general-purpose counting primitive for timers, address generators and cascaded prescalers in the Q8 counter family. A combinational terminal-count output allows several instances to be chained into wider counters.

## Interface
- `WIDTH`, 4: counter width in bits; legal range 2..16.
- `MODULUS`, 16: count range 0..MODULUS-1; legal range 2..2^WIDTH.
- `SATURATE`, 0: 0 wraps at the boundaries; 1 holds at the boundaries.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: count enable.
- `up_dn` in 1: direction; 1 counts up, 0 counts down.
- `load` in 1: synchronous parallel load.
- `load_val` in WIDTH: value applied on load.
- `clr` in 1: synchronous clear to 0.
- `ovf_clr` in 1: clears the sticky overflow flag.
- `count` out WIDTH: current count, registered.
- `tc` out 1: terminal count, combinational.
- `wrap` out 1: registered one-cycle boundary-event pulse.
- `ovf` out 1: sticky boundary-event flag.

## Operation
- **Reset.** While `reset` is low, regardless of `clk`: `count`=0, `wrap`=0, `ovf`=0. `tc` then reflects `count`=0, so it is 1 when `up_dn`=0.
- **Priority per edge:** `clr` > `load` > `en` > hold.
  - `clr`=1: `count`←0.
  - `load`=1: `count`←`load_val` when `load_val` < MODULUS, else `count`←MODULUS-1 (clamped).
  - `en`=1 with `up_dn`=1: `count`←`count`+1.
  - `en`=1 with `up_dn`=0: `count`←`count`-1.
  - Otherwise `count` holds.
- **Terminal count.** `tc` = (`up_dn` && `count`==MODULUS-1) || (!`up_dn` && `count`==0). It is independent of `en`; cascade by driving the next stage's `en` with `en && tc`.
- **Boundary event.** Occurs when `en`=1, `clr`=0, `load`=0 and `tc`=1 at the edge.
  - SATURATE=0: up wraps MODULUS-1→0; down wraps 0→MODULUS-1.
  - SATURATE=1: `count` holds at the boundary.
  - The event still fires in saturate mode on every enabled cycle spent at the boundary.
- **`wrap` pulse.** Set to 1 for exactly the cycle after each boundary event, else 0. `clr` and `load` never generate `wrap`.
- **`ovf` flag.** Set by a boundary event and cleared by `ovf_clr`. On a simultaneous boundary event and `ovf_clr`, set wins and `ovf` stays 1.
- **Width rules.** Arithmetic is performed modulo MODULUS, never modulo 2^WIDTH. `count` never exceeds MODULUS-1.
- **Direction change.** `up_dn` may change on any cycle; it takes effect on the next enabled edge with no pipeline bubble.

## Timing
- Latency is 1 cycle from `en`, `load` or `clr` sampled high to the new `count`.
- `wrap` and `ovf` update on the same edge as the boundary-event `count` update.
- `tc` settles combinationally from `count` and `up_dn` within the same cycle.
- **Reset mid-operation.** Asserting `reset` zeroes all registers immediately, without waiting for a clock edge.
- **Reset release.** Deassertion is expected to be synchronised externally. The first edge after release with `en`=1 counts from 0.
- There is no internal state beyond `count`, `wrap` and `ovf`; there is no hidden prescaler.

## Test plan
- **Reset and free-run up.** WIDTH=4, MODULUS=10, SATURATE=0; hold `reset` low, then release with `en`=1, `up_dn`=1 for 12 cycles → `count` runs 0..9,0,1. `tc`=1 while `count`=9. `wrap`=1 for the single cycle where `count`=0 after 9. `ovf`=1 from that point on.
- **Down wrap and ovf clear.** MODULUS=10; load 1, then count down 3 cycles → `count` 1,0,9,8. `wrap` pulses once. Assert `ovf_clr` on the same edge as a further 0→9 wrap → `ovf` stays 1. Assert `ovf_clr` one cycle later with no event → `ovf`=0.
- **Saturate mode.** SATURATE=1, MODULUS=10; count up from 7 for 5 cycles → `count` 8,9,9,9,9. `wrap` stays high for the last 3 cycles. Then `up_dn`=0 → `count` 8.
- **Load, clamp and priority.** MODULUS=10:
  - `load_val`=12 → `count`=9.
  - `load`=1 and `clr`=1 together → `count`=0.
  - `load`=1, `load_val`=5, `en`=1 → `count`=5, no increment.
  - None of these cases pulses `wrap`.
- **Asynchronous reset mid-count.** `count`=6; drop `reset` between clock edges → `count`, `wrap` and `ovf` go to 0 before the next edge and hold while `reset` is low.
- **Cascade.** Two instances, WIDTH=4, MODULUS=16; drive the high stage's `en` with the low stage's `en && tc` and run 300 enabled cycles up → the combined {hi,lo} value equals 300 mod 256 = 44. The high stage advances exactly once per low-stage wrap.
